// File: rtl/aoi_pipe.sv
// Selectable AND/OR/invert function on three operands, carried through a
// STAGES-deep valid/ready pipeline with per-beat popcount and a delivered-beat counter.
module aoi_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16,
    localparam int OW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [OW-1:0]    out_ones,
    output logic [CNT_W-1:0] beat_cnt
);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [OW-1:0]     ones_q [STAGES];
    logic [WIDTH-1:0]  fn_q;

    function automatic logic [OW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        fn_q = '0;
        case (in_op)
            2'd0: fn_q = ~((in_a & in_b) | in_c);
            2'd1: fn_q = ~((in_a | in_b) & in_c);
            2'd2: fn_q = (in_a & in_b) | in_c;
            2'd3: fn_q = (in_a | in_b) & in_c;
            default: fn_q = '0;
        endcase
    end

    // Ready ripples from the output back to the input, one stage at a time.
    always_comb begin
        logic rdy;
        adv = '0;
        rdy = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = vld[k] & rdy;
            rdy    = ~vld[k] | adv[k];
        end
        in_ready = rdy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            beat_cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                ones_q[k] <= '0;
            end
        end else begin
            if (~vld[0] | adv[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= fn_q;
                    ones_q[0] <= popcnt(fn_q);
                end
            end
            // A stage refills whenever it is empty or draining, so bubbles collapse.
            for (int k = 1; k < STAGES; k++) begin
                if (~vld[k] | adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        data_q[k] <= data_q[k-1];
                        ones_q[k] <= ones_q[k-1];
                    end
                end
            end
            if (adv[STAGES-1]) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_q     = data_q[STAGES-1];
    assign out_ones  = ones_q[STAGES-1];

endmodule

// File: tb/tb_aoi_pipe.sv
// Directed and scoreboard bench for aoi_pipe: default build plus a
// WIDTH=4, STAGES=1, CNT_W=4 build for counter wrap and single-stage ready.
module tb_aoi_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0, in_b = '0, in_c = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_q;
    logic [3:0]  out_ones;
    logic [15:0] beat_cnt;

    logic        w_rst = 1'b1;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [3:0]  w_a = 4'h9, w_b = 4'hF, w_c = 4'h0;
    logic [1:0]  w_op = 2'd2;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic [3:0]  w_q;
    logic [2:0]  w_ones;
    logic [3:0]  w_cnt;

    aoi_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_ones(out_ones), .beat_cnt(beat_cnt)
    );

    aoi_pipe #(.WIDTH(4), .STAGES(1), .CNT_W(4)) u_wrap (
        .clk(clk), .rst(w_rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_a), .in_b(w_b), .in_c(w_c), .in_op(w_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_q(w_q), .out_ones(w_ones), .beat_cnt(w_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q    [4] = '{8'h30, 8'hF3, 8'hCF, 8'h0C};
    logic [3:0] exp_ones [4] = '{4'd2, 4'd6, 4'd6, 4'd2};
    logic [7:0] recv [$];
    logic [7:0] sb_q [$];
    logic [3:0] sb_o [$];
    logic [3:0] hist [17];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) next_cyc();
        rst = 1'b0;
    endtask

    // Consumer always ready, producer idle; collects every delivered beat.
    task automatic drain(input int ncyc);
        recv.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < ncyc; i++) begin
            if (out_valid) recv.push_back(out_q);
            next_cyc();
        end
    endtask

    function automatic logic [7:0] ref_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [1:0] op);
        case (op)
            2'd0:    return ~((a & b) | c);
            2'd1:    return ~((a | b) & c);
            2'd2:    return (a & b) | c;
            default: return (a | b) & c;
        endcase
    endfunction

    initial begin
        int acc, hold_err, sent, got_n, cyc, rand_err, stale, wd, wc;
        logic acc_now, xfer;
        logic [7:0] eq;
        logic [3:0] eo;

        // reset state
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_beat_cnt", beat_cnt, 16'd0);
        check("rst_out_q", out_q, 8'd0);
        check("rst_out_ones", out_ones, 4'd0);
        do_reset();
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // function check, one beat per op
        out_ready = 1'b1;
        in_a = 8'hF0; in_b = 8'hCC; in_c = 8'h0F;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_op    = 2'(i);
            next_cyc();
            if (i >= 1 && i <= 4) begin
                check($sformatf("fn_valid_op%0d", i - 1), out_valid, 1'b1);
                check($sformatf("fn_q_op%0d", i - 1), out_q, exp_q[i-1]);
                check($sformatf("fn_ones_op%0d", i - 1), out_ones, exp_ones[i-1]);
            end
        end
        check("fn_idle_valid", out_valid, 1'b0);
        check("fn_beat_cnt", beat_cnt, 16'd4);

        // full backpressure
        do_reset();
        in_b = 8'hFF; in_c = 8'h00; in_op = 2'd2;
        acc = 0; hold_err = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(17 * (acc + 1));
            #1;
            if (in_ready) acc++;
            next_cyc();
            if (i >= 1 && out_q !== 8'h11) hold_err++;
        end
        check("bp_accepted", acc, 2);
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_hold_q", out_q, 8'h11);
        check("bp_hold_errs", hold_err, 0);
        drain(3);
        check("bp_drain_n", recv.size(), 2);
        check("bp_drain_0", recv[0], 8'h11);
        check("bp_drain_1", recv[1], 8'h22);
        check("bp_beat_cnt", beat_cnt, 16'd2);

        // bubble collapse
        do_reset();
        in_a = 8'h5A; in_valid = 1'b1;
        #1;
        check("bub_rdy_a", in_ready, 1'b1);
        next_cyc();
        in_valid = 1'b0;
        repeat (3) next_cyc();
        in_a = 8'hA5; in_valid = 1'b1;
        #1;
        check("bub_rdy_b", in_ready, 1'b1);
        next_cyc();
        in_valid = 1'b0;
        #1;
        check("bub_full", in_ready, 1'b0);
        check("bub_head", out_q, 8'h5A);
        drain(3);
        check("bub_drain_n", recv.size(), 2);
        check("bub_drain_0", recv[0], 8'h5A);
        check("bub_drain_1", recv[1], 8'hA5);

        // random streaming against a scoreboard
        do_reset();
        sent = 0; got_n = 0; cyc = 0; rand_err = 0;
        while (got_n < 10000 && cyc < 60000) begin
            if (!in_valid && sent < 10000 && $urandom_range(1, 0) == 1) begin
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                in_c     = 8'($urandom);
                in_op    = 2'($urandom);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(1, 0));
            #1;
            acc_now = in_valid & in_ready;
            if (acc_now) begin
                eq = ref_fn(in_a, in_b, in_c, in_op);
                sb_q.push_back(eq);
                sb_o.push_back(4'($countones(eq)));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) rand_err++;
                else begin
                    eq = sb_q.pop_front();
                    eo = sb_o.pop_front();
                    if (out_q !== eq || out_ones !== eo) rand_err++;
                end
                got_n++;
            end
            next_cyc();
            if (acc_now) in_valid = 1'b0;
            cyc++;
        end
        check("rand_delivered", got_n, 10000);
        check("rand_errors", rand_err, 0);
        check("rand_sb_empty", sb_q.size(), 0);
        check("rand_beat_cnt", beat_cnt, 16'd10000);

        // reset mid-stream with two beats in flight
        do_reset();
        out_ready = 1'b1;
        in_b = 8'hFF; in_c = 8'h00; in_op = 2'd2;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(i + 1);
            next_cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("mid_pre_cnt", beat_cnt, 16'd2);
        check("mid_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_cnt", beat_cnt, 16'd0);
        check("mid_rst_q", out_q, 8'd0);
        next_cyc();
        #2;
        rst = 1'b0;
        #1;
        check("mid_post_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            next_cyc();
            if (out_valid) stale++;
        end
        check("mid_no_stale", stale, 0);
        check("mid_post_cnt", beat_cnt, 16'd0);

        // counter wrap on the CNT_W=4, STAGES=1 build
        #1;
        check("w_rst_cnt", w_cnt, 4'd0);
        w_rst = 1'b0;
        w_in_valid = 1'b1; w_out_ready = 1'b1;
        wd = 0; wc = 0;
        while (wd < 17 && wc < 60) begin
            #1;
            xfer = w_out_valid & w_out_ready;
            next_cyc();
            if (xfer) begin
                hist[wd] = w_cnt;
                wd++;
            end
            wc++;
        end
        check("w_delivered", wd, 17);
        check("w_cnt_15", hist[14], 4'd15);
        check("w_cnt_16", hist[15], 4'd0);
        check("w_cnt_17", hist[16], 4'd1);
        check("w_q", w_q, 4'h9);
        check("w_ones", w_ones, 3'd2);
        w_out_ready = 1'b0;
        #1;
        check("w_s1_stalled", w_in_ready, 1'b0);
        w_out_ready = 1'b1;
        #1;
        check("w_s1_pass", w_in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
